// File: rtl/mem_lane_sched_pkg.sv
// mem_lane_sched_pkg
// Shared types and defaults for the two-lane data-memory access scheduler.
//   sched_state_e : scheduler FSM states (IDLE, ISSUE1, ISSUE2, DONE)
//   lane_req_t    : one captured lane request {req, wr, addr, wdata}
//   DEF_ADDR_BASE / DEF_N_WORDS : default data window
//   OOR_DATA      : load result returned for an out-of-window or misaligned lane
package mem_lane_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE1 = 2'd1,
    ISSUE2 = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h1000_0000;
  localparam int          DEF_N_WORDS   = 4;
  localparam logic [31:0] OOR_DATA      = 32'h0000_0020;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lane_req_t;

endpackage

// File: rtl/mem_lane_sched_if.sv
// mem_lane_sched_if
// Bundle of all non-clock signals of the scheduler: the two MEM-stage lanes,
// the pipeline stall, the per-lane results and the single data-memory port.
//   modport slave  : the scheduler (consumes lane requests, drives results and memory port)
//   modport master : pipeline + data memory side (drives requests and Dato_Mem_out)
//
// Handshake: a bundle is accepted in the cycle where the scheduler is idle and
// req_1 | req_2 is high; stall then stays high until the result cycle, in which
// rvalid_k pulses for one cycle for every requested lane. Lane inputs presented
// while stall is high are ignored, so the pipeline simply keeps them steady.
interface mem_lane_sched_if;
  logic        req_1, req_2;
  logic        wr_1, wr_2;
  logic [31:0] addr_1, addr_2;
  logic [31:0] wdata_1, wdata_2;
  logic        stall;
  logic        rvalid_1, rvalid_2;
  logic [31:0] rdata_1, rdata_2;
  logic        err_1, err_2;
  logic        Mem_rd_n, Mem_wr_n;
  logic [31:0] Dir_Mem;
  logic [31:0] Dato_Mem_in;
  logic [31:0] Dato_Mem_out;

  modport slave (
    input  req_1, req_2, wr_1, wr_2, addr_1, addr_2, wdata_1, wdata_2, Dato_Mem_out,
    output stall, rvalid_1, rvalid_2, rdata_1, rdata_2, err_1, err_2,
           Mem_rd_n, Mem_wr_n, Dir_Mem, Dato_Mem_in
  );

  modport master (
    output req_1, req_2, wr_1, wr_2, addr_1, addr_2, wdata_1, wdata_2, Dato_Mem_out,
    input  stall, rvalid_1, rvalid_2, rdata_1, rdata_2, err_1, err_2,
           Mem_rd_n, Mem_wr_n, Dir_Mem, Dato_Mem_in
  );
endinterface

// File: rtl/mem_lane_addr_chk.sv
// mem_lane_addr_chk
// Combinational address check for one lane: the access is legal when it is
// word aligned and falls inside [ADDR_BASE, ADDR_BASE + 4*N_WORDS).
//   addr : byte address to check
//   ok   : 1 = legal access
module mem_lane_addr_chk
  import mem_lane_sched_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter int          N_WORDS   = DEF_N_WORDS
) (
  input  logic [31:0] addr,
  output logic        ok
);
  // Upper bound kept in 33 bits so a window ending at 2^32 does not wrap.
  localparam logic [32:0] WIN_END = {1'b0, ADDR_BASE} + (33'(N_WORDS) << 2);

  assign ok = (addr[1:0] == 2'b00) &&
              (addr >= ADDR_BASE) &&
              ({1'b0, addr} < WIN_END);
endmodule

// File: rtl/mem_lane_sched.sv
// mem_lane_sched
// Two-lane data-memory access scheduler. Accepts one bundle of up to two
// load/store requests while idle and serializes them onto the single memory
// port in program order (lane 1 first), stalling the pipeline until the
// results pulse out together in the DONE cycle.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mem_lane_sched_if.slave (lanes, stall, results, memory port)
//   state_dbg  : current FSM state, for observation
// Optional feature: define MEM_LANE_SCHED_FWD_EN to forward lane-1 store data
// to a lane-2 load of the same address, skipping the second memory access.
module mem_lane_sched
  import mem_lane_sched_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter int          N_WORDS   = DEF_N_WORDS
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_lane_sched_if.slave     bus,
  output sched_state_e        state_dbg
);

  sched_state_e state, state_d;

  lane_req_t in_1, in_2;
  lane_req_t cap_1, cap_2;
  logic      cap_fwd;
  logic      fwd_in;

  logic [31:0] chk_addr_1, chk_addr_2;
  logic        ok_1, ok_2;

  // Issue lane selected for the next cycle's memory access
  lane_req_t iss;
  logic      iss_ok;

  logic        rd_n_q, wr_n_q, rd_n_d, wr_n_d;
  logic [31:0] dir_q, dir_d, dout_q, dout_d;
  logic [31:0] rdata_1_q, rdata_2_q;

  assign in_1 = {bus.req_1, bus.wr_1, bus.addr_1, bus.wdata_1};
  assign in_2 = {bus.req_2, bus.wr_2, bus.addr_2, bus.wdata_2};

  // While idle the checkers look at the incoming bundle; afterwards at the
  // captured one, so ok_k always describes the lane currently being handled.
  assign chk_addr_1 = (state == IDLE) ? in_1.addr : cap_1.addr;
  assign chk_addr_2 = (state == IDLE) ? in_2.addr : cap_2.addr;

  mem_lane_addr_chk #(.ADDR_BASE(ADDR_BASE), .N_WORDS(N_WORDS)) u_chk_1 (
    .addr (chk_addr_1),
    .ok   (ok_1)
  );

  mem_lane_addr_chk #(.ADDR_BASE(ADDR_BASE), .N_WORDS(N_WORDS)) u_chk_2 (
    .addr (chk_addr_2),
    .ok   (ok_2)
  );

`ifdef MEM_LANE_SCHED_FWD_EN
  assign fwd_in = in_1.req && in_1.wr && ok_1 &&
                  in_2.req && !in_2.wr && ok_2 &&
                  (in_1.addr == in_2.addr);
`else
  assign fwd_in = 1'b0;
  // Lane-1 store data is only needed by the forwarding path.
  logic unused_cap_1_wdata;
  assign unused_cap_1_wdata = ^cap_1.wdata;
`endif

  // Next state and the memory-port values that will be registered for it.
  always_comb begin
    state_d = state;
    iss     = '0;
    iss_ok  = 1'b0;
    rd_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    dir_d   = 32'h0;
    dout_d  = dout_q;

    case (state)
      IDLE: begin
        if (in_1.req || in_2.req) state_d = in_1.req ? ISSUE1 : ISSUE2;
      end
      ISSUE1:  state_d = (cap_2.req && !cap_fwd) ? ISSUE2 : DONE;
      ISSUE2:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // ISSUE1 is only ever entered from IDLE; ISSUE2 from IDLE (lane-2-only
    // bundle) or from ISSUE1 (captured lane 2).
    if (state_d == ISSUE1) begin
      iss    = in_1;
      iss_ok = ok_1;
    end else if (state_d == ISSUE2) begin
      iss    = (state == IDLE) ? in_2 : cap_2;
      iss_ok = ok_2;
    end

    if (state_d == ISSUE1 || state_d == ISSUE2) begin
      dir_d = iss.addr;
      if (iss_ok) begin
        if (iss.wr) begin
          wr_n_d = 1'b0;
          dout_d = iss.wdata;
        end else begin
          rd_n_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_1     <= '0;
      cap_2     <= '0;
      cap_fwd   <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      dir_q     <= 32'h0;
      dout_q    <= 32'h0;
      rdata_1_q <= 32'h0;
      rdata_2_q <= 32'h0;
    end else begin
      state  <= state_d;
      rd_n_q <= rd_n_d;
      wr_n_q <= wr_n_d;
      dir_q  <= dir_d;
      dout_q <= dout_d;

      if (state == IDLE && (in_1.req || in_2.req)) begin
        cap_1   <= in_1;
        cap_2   <= in_2;
        cap_fwd <= fwd_in;
      end

      // Results are captured at the end of the lane's ISSUE cycle; store
      // lanes leave rdata untouched unless the address was illegal.
      if (state == ISSUE1) begin
        if (!ok_1)           rdata_1_q <= OOR_DATA;
        else if (!cap_1.wr)  rdata_1_q <= bus.Dato_Mem_out;
`ifdef MEM_LANE_SCHED_FWD_EN
        if (cap_fwd)         rdata_2_q <= cap_1.wdata;
`endif
      end

      if (state == ISSUE2) begin
        if (!ok_2)           rdata_2_q <= OOR_DATA;
        else if (!cap_2.wr)  rdata_2_q <= bus.Dato_Mem_out;
      end
    end
  end

  assign bus.stall = (state == IDLE && (in_1.req || in_2.req)) ||
                     (state == ISSUE1) || (state == ISSUE2);

  assign bus.rvalid_1 = (state == DONE) && cap_1.req;
  assign bus.rvalid_2 = (state == DONE) && cap_2.req;
  assign bus.err_1    = bus.rvalid_1 && !ok_1;
  assign bus.err_2    = bus.rvalid_2 && !ok_2;

  assign bus.rdata_1     = rdata_1_q;
  assign bus.rdata_2     = rdata_2_q;
  assign bus.Mem_rd_n    = rd_n_q;
  assign bus.Mem_wr_n    = wr_n_q;
  assign bus.Dir_Mem     = dir_q;
  assign bus.Dato_Mem_in = dout_q;

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_lane_sched.sv
// tb_mem_lane_sched
// Bench for mem_lane_sched: directed bundles from the test plan followed by
// random bundles, each compared against a word-array memory model that
// applies the lanes in program order.
module tb_mem_lane_sched;
  import mem_lane_sched_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_lane_sched_if bus ();
  sched_state_e state_dbg;

  mem_lane_sched #(.ADDR_BASE(BASE), .N_WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- data memory ----------------
  logic [31:0] mem [4];
  logic        mem_init;

  function automatic bit win_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[3:2]);
  endfunction

  always_comb begin
    bus.Dato_Mem_out = 32'h0;
    if (!bus.Mem_rd_n && win_ok(bus.Dir_Mem)) bus.Dato_Mem_out = mem[widx(bus.Dir_Mem)];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      mem[0] <= 32'h8;
      mem[1] <= 32'hD;
      mem[2] <= 32'h2;
      mem[3] <= 32'h10;
    end else if (!bus.Mem_wr_n && win_ok(bus.Dir_Mem)) begin
      mem[widx(bus.Dir_Mem)] <= bus.Dato_Mem_in;
    end
  end

  // ---------------- scoreboard / reference ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [4];
  logic [31:0] exp_rd1, exp_rd2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one lane to the word-array model; returns the lane's load result.
  task automatic model_lane(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, inout logic [31:0] rd);
    if (r) begin
      if (!win_ok(a))  rd = OOR_DATA;
      else if (w)      mdl[widx(a)] = d;
      else             rd = mdl[widx(a)];
      exp_q.push_back(rd);
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_inputs();
    bus.req_1 = 0; bus.req_2 = 0; bus.wr_1 = 0; bus.wr_2 = 0;
    bus.addr_1 = 0; bus.addr_2 = 0; bus.wdata_1 = 0; bus.wdata_2 = 0;
  endtask

  // Called at a falling edge with the scheduler idle; returns at a falling edge.
  task automatic run_bundle(input string nm,
                            input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                            input bit r2, input bit w2, input logic [31:0] a2, input logic [31:0] d2);
    int n_iss, n_strb, fwd, stall_cnt, strb_cnt, got_k;
    logic [31:0] e;
    fwd = 0;
`ifdef MEM_LANE_SCHED_FWD_EN
    if (r1 && w1 && win_ok(a1) && r2 && !w2 && win_ok(a2) && a1 == a2) fwd = 1;
`endif
    n_iss  = int'(r1) + int'(r2) - fwd;
    n_strb = int'(r1 && win_ok(a1)) + int'(r2 && win_ok(a2)) - fwd;
    model_lane(r1, w1, a1, d1, exp_rd1);
    model_lane(r2, w2, a2, d2, exp_rd2);

    bus.req_1 = r1; bus.wr_1 = w1; bus.addr_1 = a1; bus.wdata_1 = d1;
    bus.req_2 = r2; bus.wr_2 = w2; bus.addr_2 = a2; bus.wdata_2 = d2;
    #1;
    check_val({nm, ":stall_accept"}, 32'(bus.stall), 32'd1);

    stall_cnt = 1;
    strb_cnt  = 0;
    got_k     = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.stall) stall_cnt++;
      if (!bus.Mem_rd_n || !bus.Mem_wr_n) strb_cnt++;
      if (!bus.Mem_rd_n && !bus.Mem_wr_n)
        check_val({nm, ":strobe_excl"}, 32'd1, 32'd0);
      if (bus.rvalid_1 || bus.rvalid_2) begin
        got_k = k;
        break;
      end
    end

    check_val({nm, ":latency"}, 32'(got_k), 32'(n_iss + 1));
    check_val({nm, ":stall_cycles"}, 32'(stall_cnt), 32'(n_iss + 1));
    check_val({nm, ":strobe_cycles"}, 32'(strb_cnt), 32'(n_strb));

    if (got_k != 0) begin
      check_val({nm, ":rvalid_1"}, 32'(bus.rvalid_1), 32'(r1));
      check_val({nm, ":rvalid_2"}, 32'(bus.rvalid_2), 32'(r2));
      check_val({nm, ":err_1"}, 32'(bus.err_1), 32'(r1 && !win_ok(a1)));
      check_val({nm, ":err_2"}, 32'(bus.err_2), 32'(r2 && !win_ok(a2)));
      check_val({nm, ":done_dir"}, bus.Dir_Mem, 32'h0);
      if (r1) begin
        e = exp_q.pop_front();
        check_val({nm, ":rdata_1"}, bus.rdata_1, e);
      end else begin
        check_val({nm, ":rdata_1_hold"}, bus.rdata_1, exp_rd1);
      end
      if (r2) begin
        e = exp_q.pop_front();
        check_val({nm, ":rdata_2"}, bus.rdata_2, e);
      end else begin
        check_val({nm, ":rdata_2_hold"}, bus.rdata_2, exp_rd2);
      end
    end
    exp_q.delete();

    clear_inputs();
    @(negedge clk);
    check_val({nm, ":rvalid_pulse"}, 32'(bus.rvalid_1 | bus.rvalid_2), 32'd0);
    check_val({nm, ":idle_state"}, 32'(state_dbg), 32'(IDLE));
    check_val({nm, ":idle_stall"}, 32'(bus.stall), 32'd0);
  endtask

  task automatic check_reset_values(input string nm);
    check_val({nm, ":stall"}, 32'(bus.stall), 32'd0);
    check_val({nm, ":rvalid"}, 32'({bus.rvalid_1, bus.rvalid_2}), 32'd0);
    check_val({nm, ":err"}, 32'({bus.err_1, bus.err_2}), 32'd0);
    check_val({nm, ":rdata_1"}, bus.rdata_1, 32'h0);
    check_val({nm, ":rdata_2"}, bus.rdata_2, 32'h0);
    check_val({nm, ":strobes"}, 32'({bus.Mem_rd_n, bus.Mem_wr_n}), 32'd3);
    check_val({nm, ":dir"}, bus.Dir_Mem, 32'h0);
    check_val({nm, ":dout"}, bus.Dato_Mem_in, 32'h0);
    check_val({nm, ":state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return BASE + 32'($urandom_range(0, 3)) * 32'd4;
      4:          return BASE + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(1, 3));
      5:          return BASE - 32'd4;
      6:          return BASE + 32'd16;
      default:    return 32'h2000_0000;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a1, a2;
    int rr;
    clear_inputs();
    mem_init = 1'b1;
    mdl[0] = 32'h8; mdl[1] = 32'hD; mdl[2] = 32'h2; mdl[3] = 32'h10;
    exp_rd1 = 32'h0;
    exp_rd2 = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Lane-1-only load
    run_bundle("ld1", 1, 0, 32'h1000_0004, 32'h0, 0, 0, 32'h0, 32'h0);
    check_val("ld1:value", bus.rdata_1, 32'hD);

    // Store then load of the same word in one bundle
    run_bundle("st_ld", 1, 1, 32'h1000_0008, 32'h55, 1, 0, 32'h1000_0008, 32'h0);
    check_val("st_ld:value", bus.rdata_2, 32'h55);

    // Two stores to one word: lane 2 wins
    run_bundle("st_st", 1, 1, 32'h1000_000C, 32'h11, 1, 1, 32'h1000_000C, 32'h22);
    check_val("st_st:mem", mem[3], 32'h22);

    // Lane-2-only out-of-window load
    run_bundle("oor2", 0, 0, 32'h0, 32'h0, 1, 0, 32'h2000_0000, 32'h0);
    check_val("oor2:value", bus.rdata_2, 32'h20);

    // Reset during ISSUE2 of a dual load bundle
    bus.req_1 = 1; bus.wr_1 = 0; bus.addr_1 = 32'h1000_0000;
    bus.req_2 = 1; bus.wr_2 = 0; bus.addr_2 = 32'h1000_0004;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_mid:in_issue2", 32'(state_dbg), 32'(ISSUE2));
    check_val("rst_mid:rd_strobe", 32'(bus.Mem_rd_n), 32'd0);
    clear_inputs();
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_mid:strobes", 32'({bus.Mem_rd_n, bus.Mem_wr_n}), 32'd3);
    check_val("rst_mid:state", 32'(state_dbg), 32'(IDLE));
    check_val("rst_mid:dir", bus.Dir_Mem, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("rst_mid:no_rvalid", 32'({bus.rvalid_1, bus.rvalid_2}), 32'd0);
    end
    exp_rd1 = 32'h0;
    exp_rd2 = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    run_bundle("post_rst", 1, 0, 32'h1000_0000, 32'h0, 1, 0, 32'h1000_0004, 32'h0);

    // Random bundles
    for (int n = 0; n < 40; n++) begin
      rr = int'($urandom_range(1, 3));
      a1 = rand_addr();
      a2 = ($urandom_range(0, 3) == 0) ? a1 : rand_addr();
      run_bundle($sformatf("rnd%0d", n),
                 rr[0], 1'($urandom_range(0, 1)), a1, $urandom,
                 rr[1], 1'($urandom_range(0, 1)), a2, $urandom);
    end

    for (int i = 0; i < 4; i++) check_val($sformatf("mem_final%0d", i), mem[i], mdl[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
